// File: rtl/lshift_pkg.sv
// ---------------------------------------------------------------------------
// lshift_pkg
// Shared definitions for the lshift_reg rotate/shift register slice.
//   LSHIFT_DEF_WIDTH : default register width in bits
//   lshift_data_t    : data vector type at the default width
// ---------------------------------------------------------------------------
package lshift_pkg;

    localparam int LSHIFT_DEF_WIDTH = 8;

    typedef logic [LSHIFT_DEF_WIDTH-1:0] lshift_data_t;

endpackage : lshift_pkg

// File: rtl/lshift_reg_if.sv
// ---------------------------------------------------------------------------
// lshift_reg_if
// Groups the load bus and the register output of lshift_reg.
//   load_val : parallel load value                (master -> slave)
//   load_en  : load request for the next edge     (master -> slave)
//   out      : registered register contents       (slave  -> master)
// Modports: master (stimulus / consumer side), slave (the register).
// ---------------------------------------------------------------------------
interface lshift_reg_if
    import lshift_pkg::*;
#(
    parameter int WIDTH = LSHIFT_DEF_WIDTH
) ();

    logic [WIDTH-1:0] load_val;
    logic             load_en;
    logic [WIDTH-1:0] out;

    modport master (
        output load_val,
        output load_en,
        input  out
    );

    modport slave (
        input  load_val,
        input  load_en,
        output out
    );

endinterface : lshift_reg_if

// File: rtl/lshift_step.sv
// ---------------------------------------------------------------------------
// lshift_step
// Combinational one-position left step of a WIDTH-bit vector.
//   din  : current register contents
//   dout : din rotated left by one (MSB wraps into LSB), or, when the
//          LSHIFT_ZERO_FILL_EN macro is defined, shifted left with a 0
//          entering the LSB.
// ---------------------------------------------------------------------------
module lshift_step
    import lshift_pkg::*;
#(
    parameter int WIDTH = LSHIFT_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // The MSB is gated rather than dropped so both builds read every input
    // bit; in the zero-fill build the gate folds to a constant 0.
`ifdef LSHIFT_ZERO_FILL_EN
    localparam logic WRAP_MSB = 1'b0;
`else
    localparam logic WRAP_MSB = 1'b1;
`endif

    // Per-bit left step: bit i moves to bit i+1, LSB takes the wrap/fill bit.
    always_comb begin
        dout = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH - 1; i++) begin
            dout[i+1] = din[i];
        end
        dout[0] = din[WIDTH-1] & WRAP_MSB;
    end

endmodule : lshift_step

// File: rtl/lshift_reg.sv
// ---------------------------------------------------------------------------
// lshift_reg
// Parallel-load, left-rotating shift register (walking-one / pattern source).
// Each rising edge: synchronous reset to 0, else load, else step left by one.
//   clk       : rising-edge clock
//   rstn      : synchronous active-low reset (sampled on clk only)
//   bus.slave : load_val / load_en inputs, out (flop-driven) output
// Parameter WIDTH (>= 2) must match the WIDTH of the connected interface.
// Build option: define LSHIFT_ZERO_FILL_EN to turn the rotate into a logical
// left shift (0 enters the LSB); reset and load are unchanged.
// ---------------------------------------------------------------------------
module lshift_reg
    import lshift_pkg::*;
#(
    parameter int WIDTH = LSHIFT_DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rstn,
    lshift_reg_if.slave  bus
);

    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] out_r;

    lshift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .din  (out_r),
        .dout (step_s)
    );

    // Register with priority reset > load > step.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_r <= {WIDTH{1'b0}};
        end else if (bus.load_en) begin
            out_r <= bus.load_val;
        end else begin
            out_r <= step_s;
        end
    end

    assign bus.out = out_r;

endmodule : lshift_reg

// File: tb/tb_lshift_reg.sv
// ---------------------------------------------------------------------------
// tb_lshift_reg
// Self-checking bench for lshift_reg at WIDTH 8, 4 and 16 in parallel.
// A reference model predicts each instance's next value when inputs are
// driven; the prediction is queued and compared after the clock edge.
// Test-plan values are also checked against literal constants.
// ---------------------------------------------------------------------------
module tb_lshift_reg;

    typedef struct packed {
        logic [15:0] e8;
        logic [15:0] e4;
        logic [15:0] e16;
    } exp_t;

    logic clk;
    logic rstn;

    lshift_reg_if #(.WIDTH(8))  if8  ();
    lshift_reg_if #(.WIDTH(4))  if4  ();
    lshift_reg_if #(.WIDTH(16)) if16 ();

    lshift_reg #(.WIDTH(8))  u_dut8  (.clk(clk), .rstn(rstn), .bus(if8.slave));
    lshift_reg #(.WIDTH(4))  u_dut4  (.clk(clk), .rstn(rstn), .bus(if4.slave));
    lshift_reg #(.WIDTH(16)) u_dut16 (.clk(clk), .rstn(rstn), .bus(if16.slave));

    exp_t        sb[$];
    logic [15:0] m8;
    logic [15:0] m4;
    logic [15:0] m16;
    int          n_tests;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference next-state for a w-bit register held in the low bits.
    function automatic logic [15:0] model_next(input logic [15:0] cur,
                                               input logic r, input logic en,
                                               input logic [15:0] lv, input int w);
        logic [15:0] mask;
        logic [15:0] nxt;
        mask = (w == 16) ? 16'hFFFF : ((16'h0001 << w) - 16'h0001);
        if (!r) begin
            nxt = 16'h0000;
        end else if (en) begin
            nxt = lv & mask;
        end else begin
            nxt = (cur << 1) & mask;
`ifndef LSHIFT_ZERO_FILL_EN
            nxt = nxt | ((cur >> (w - 1)) & 16'h0001);
`endif
        end
        return nxt;
    endfunction

    // One clock: drive, predict, enqueue, edge, dequeue and compare.
    task automatic cyc(input string name, input logic r, input logic en,
                       input logic [15:0] v8, input logic [15:0] v4,
                       input logic [15:0] v16);
        exp_t e;
        rstn          = r;
        if8.load_en   = en;
        if8.load_val  = v8[7:0];
        if4.load_en   = en;
        if4.load_val  = v4[3:0];
        if16.load_en  = en;
        if16.load_val = v16;
        m8  = model_next(m8,  r, en, v8,  8);
        m4  = model_next(m4,  r, en, v4,  4);
        m16 = model_next(m16, r, en, v16, 16);
        e.e8  = m8;
        e.e4  = m4;
        e.e16 = m16;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if ({8'h00, if8.out} !== e.e8) begin
                n_fail++;
                $display("FAIL %s w8: got %h expected %h", name, if8.out, e.e8[7:0]);
            end
            n_tests++;
            if ({12'h000, if4.out} !== e.e4) begin
                n_fail++;
                $display("FAIL %s w4: got %h expected %h", name, if4.out, e.e4[3:0]);
            end
            n_tests++;
            if (if16.out !== e.e16) begin
                n_fail++;
                $display("FAIL %s w16: got %h expected %h", name, if16.out, e.e16);
            end
        end
    endtask

    task automatic test_reset();
        cyc("reset_low", 1'b0, 1'b0, 16'h00FF, 16'h000F, 16'hFFFF);
        cyc("reset_low", 1'b0, 1'b0, 16'h00FF, 16'h000F, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            cyc("reset_release", 1'b1, 1'b0, 16'h005A, 16'h0005, 16'h5A5A);
        end
        n_tests++;
        if (if8.out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_const: got %h expected 00", if8.out);
        end
    endtask

    task automatic test_load_hold();
        for (int i = 0; i < 7; i++) begin
            cyc("load_hold", 1'b1, 1'b1, 16'h0001, 16'h0001, 16'h0001);
            n_tests++;
            if (if8.out !== 8'h01) begin
                n_fail++;
                $display("FAIL load_hold_const: got %h expected 01", if8.out);
            end
        end
    endtask

    task automatic test_walking_one();
        logic [7:0] walk [8];
        walk = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
`ifdef LSHIFT_ZERO_FILL_EN
        walk[7] = 8'h00;
`endif
        cyc("walk_load", 1'b1, 1'b1, 16'h0001, 16'h0001, 16'h0001);
        // load_val is randomised while load_en is low: it must be ignored.
        for (int k = 0; k < 8; k++) begin
            cyc("walk_step", 1'b1, 1'b0, 16'($urandom_range(255)),
                16'($urandom_range(15)), 16'($urandom_range(65535)));
            n_tests++;
            if (if8.out !== walk[k]) begin
                n_fail++;
                $display("FAIL walk_const[%0d]: got %h expected %h", k, if8.out, walk[k]);
            end
        end
    endtask

    task automatic test_multi_bit();
        logic [7:0] second;
`ifdef LSHIFT_ZERO_FILL_EN
        second = 8'h94;
`else
        second = 8'h96;
`endif
        cyc("multi_load", 1'b1, 1'b1, 16'h00A5, 16'h0005, 16'h00A5);
        cyc("multi_rot1", 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        n_tests++;
        if (if8.out[7:1] !== 7'b0100101) begin
            n_fail++;
            $display("FAIL multi_const1: got %h expected 4b/4a", if8.out);
        end
        cyc("multi_rot2", 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        n_tests++;
        if (if8.out !== second) begin
            n_fail++;
            $display("FAIL multi_const2: got %h expected %h", if8.out, second);
        end
    endtask

    task automatic test_reset_priority();
        cyc("rst_over_load", 1'b0, 1'b1, 16'h00FF, 16'h000F, 16'hFFFF);
        n_tests++;
        if (if8.out !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_over_load_const: got %h expected 00", if8.out);
        end
        cyc("mid_load", 1'b1, 1'b1, 16'h0008, 16'h0008, 16'h0008);
        cyc("mid_rot", 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        n_tests++;
        if (if8.out !== 8'h10) begin
            n_fail++;
            $display("FAIL mid_rot_const: got %h expected 10", if8.out);
        end
        cyc("mid_reset", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        n_tests++;
        if (if8.out !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_const: got %h expected 00", if8.out);
        end
    endtask

    task automatic test_params();
        logic [3:0]  exp4;
        logic [15:0] exp16;
`ifdef LSHIFT_ZERO_FILL_EN
        exp4  = 4'h0;
        exp16 = 16'h0000;
`else
        exp4  = 4'h1;
        exp16 = 16'h0001;
`endif
        cyc("param_load", 1'b1, 1'b1, 16'h0080, 16'h0008, 16'h8000);
        cyc("param_rot", 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        n_tests++;
        if (if4.out !== exp4) begin
            n_fail++;
            $display("FAIL param_w4_const: got %h expected %h", if4.out, exp4);
        end
        n_tests++;
        if (if16.out !== exp16) begin
            n_fail++;
            $display("FAIL param_w16_const: got %h expected %h", if16.out, exp16);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            cyc("b2b", 1'b1, 1'($urandom_range(1)), 16'($urandom_range(255)),
                16'($urandom_range(15)), 16'($urandom_range(65535)));
        end
        for (int i = 0; i < 20; i++) begin
            cyc("b2b_rot", 1'b1, 1'b0, 16'($urandom_range(255)),
                16'($urandom_range(15)), 16'($urandom_range(65535)));
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        m8            = 16'h0000;
        m4            = 16'h0000;
        m16           = 16'h0000;
        rstn          = 1'b0;
        if8.load_en   = 1'b0;
        if8.load_val  = 8'h00;
        if4.load_en   = 1'b0;
        if4.load_val  = 4'h0;
        if16.load_en  = 1'b0;
        if16.load_val = 16'h0000;

        test_reset();
        test_load_hold();
        test_walking_one();
        test_multi_bit();
        test_reset_priority();
        test_params();
        test_back_to_back();

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_lshift_reg
